branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_unit.sv | 153 +++++++++++++++
 tb/tb_branch_unit.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_unit.sv
// Branch resolution unit: decodes branch type, computes next PC,
// conditional-move max, kill window after redirects and retire stats.
// Ports: in_* handshake + operands, out_* result handshake,
//        npc/cmov_out/taken/flush results, stat_clr/br_count/tk_count.
module branch_unit #(
  parameter int XLEN     = 32,
  parameter int KILL_CYC = 2,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  pc_plus,
  input  logic [XLEN-1:0]  a,
  input  logic [XLEN-1:0]  b,
  input  logic [2:0]       branch,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  npc,
  output logic [XLEN-1:0]  cmov_out,
  output logic             taken,
  output logic             flush,
  input  logic             stat_clr,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] tk_count
);

  typedef enum logic {RUN, HOLD} state_e;

  localparam logic [3:0] KC_INIT = 4'(KILL_CYC);

  state_e           state_q;
  logic [3:0]       kc_q;
  logic             out_valid_q;
  logic [XLEN-1:0]  npc_q;
  logic [XLEN-1:0]  cmov_q;
  logic             taken_q;
  logic             flush_q;
  logic             isbr_q;
  logic [CNT_W-1:0] br_cnt_q;
  logic [CNT_W-1:0] tk_cnt_q;

  logic             a_neg;
  logic             a_zero;
  logic             rel_tk;
  logic             is_jr;
  logic             is_br;
  logic             taken_d;
  logic [XLEN-1:0]  npc_d;
  logic [XLEN-1:0]  cmov_d;
  logic             accept;
  logic             retire;

  assign a_neg  = a[XLEN-1];
  assign a_zero = (a == '0);

  always_comb begin
    rel_tk = 1'b0;
    is_jr  = 1'b0;
    is_br  = 1'b1;
    case (branch)
      3'b001:  rel_tk = 1'b1;
      3'b010:  rel_tk = a_neg;
      3'b011:  rel_tk = !a_neg && !a_zero;
      3'b100:  rel_tk = a_zero;
      3'b101:  is_jr  = 1'b1;
      3'b110:  rel_tk = !a_zero;
      default: is_br  = 1'b0;
    endcase
  end

  assign taken_d = rel_tk | is_jr;

  always_comb begin
    npc_d = pc_plus;
    if (is_jr)
      npc_d = b;
    else if (rel_tk)
      npc_d = pc_plus + b;
  end

  assign cmov_d = ($signed(a) > $signed(b)) ? a : b;

  // Gated by rst_n so nothing is accepted while reset is held.
  assign in_ready = rst_n && (state_q == RUN)
                  && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  assign retire   = out_valid_q && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RUN;
      kc_q        <= 4'd0;
      out_valid_q <= 1'b0;
      npc_q       <= '0;
      cmov_q      <= '0;
      taken_q     <= 1'b0;
      flush_q     <= 1'b0;
      isbr_q      <= 1'b0;
      br_cnt_q    <= '0;
      tk_cnt_q    <= '0;
    end else begin
      // Pulse only on load; a stalled result never re-fires it.
      flush_q <= accept && taken_d;

      if (accept) begin
        out_valid_q <= 1'b1;
        npc_q       <= npc_d;
        cmov_q      <= cmov_d;
        taken_q     <= taken_d;
        isbr_q      <= is_br;
      end else if (retire) begin
        out_valid_q <= 1'b0;
      end

      // Kill window runs regardless of output backpressure.
      unique case (state_q)
        RUN: begin
          if (accept && taken_d && (KILL_CYC > 0)) begin
            state_q <= HOLD;
            kc_q    <= KC_INIT;
          end
        end
        HOLD: begin
          kc_q <= kc_q - 4'd1;
          if (kc_q == 4'd1)
            state_q <= RUN;
        end
        default: state_q <= RUN;
      endcase

      if (stat_clr) begin
        br_cnt_q <= '0;
        tk_cnt_q <= '0;
      end else if (retire) begin
        if (isbr_q && (br_cnt_q != '1))
          br_cnt_q <= br_cnt_q + 1'b1;
        if (taken_q && (tk_cnt_q != '1))
          tk_cnt_q <= tk_cnt_q + 1'b1;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign npc       = npc_q;
  assign cmov_out  = cmov_q;
  assign taken     = taken_q;
  assign flush     = flush_q;
  assign br_count  = br_cnt_q;
  assign tk_count  = tk_cnt_q;

endmodule

// File: tb/tb_branch_unit.sv
// Self-checking bench for branch_unit: vector table plus
// hand sequences for kill window, backpressure, counters, reset.
module tb_branch_unit;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [XLEN-1:0]  pc_plus;
  logic [XLEN-1:0]  a;
  logic [XLEN-1:0]  b;
  logic [2:0]       branch;
  logic             out_valid;
  logic             out_ready;
  logic [XLEN-1:0]  npc;
  logic [XLEN-1:0]  cmov_out;
  logic             taken;
  logic             flush;
  logic             stat_clr;
  logic [CNT_W-1:0] br_count;
  logic [CNT_W-1:0] tk_count;

  branch_unit #(.XLEN(XLEN), .KILL_CYC(2), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pc_plus(pc_plus), .a(a), .b(b), .branch(branch),
    .out_valid(out_valid), .out_ready(out_ready),
    .npc(npc), .cmov_out(cmov_out),
    .taken(taken), .flush(flush),
    .stat_clr(stat_clr),
    .br_count(br_count), .tk_count(tk_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] av;
    logic [31:0] bv;
    logic [2:0]  br;
    logic [31:0] e_npc;
    logic [31:0] e_cmov;
    logic        e_tk;
  } vec_t;

  vec_t vecs[12];
  int nchk = 0;
  int nfail = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] av,
                       input logic [31:0] bv, input logic [2:0] br);
    pc_plus = p;
    a       = av;
    b       = bv;
    branch  = br;
  endtask

  initial begin
    int e_br;
    int e_tk;
    logic [31:0] hold_npc;
    logic [CNT_W-1:0] br0;
    logic [31:0] tav[4];
    logic [31:0] tbv[4];
    logic [31:0] tex[4];

    vecs[0]  = '{32'h100, 32'h0, 32'h20, 3'b001, 32'h120, 32'h20, 1'b1};
    vecs[1]  = '{32'h40, 32'hFFFFFFFF, 32'h8, 3'b010, 32'h48, 32'h8, 1'b1};
    vecs[2]  = '{32'h40, 32'h1, 32'h8, 3'b010, 32'h40, 32'h8, 1'b0};
    vecs[3]  = '{32'h200, 32'h5, 32'hDEAD0000, 3'b101,
                 32'hDEAD0000, 32'h5, 1'b1};
    vecs[4]  = '{32'hFFFFFFFC, 32'h0, 32'h8, 3'b001, 32'h4, 32'h8, 1'b1};
    vecs[5]  = '{32'h1000, 32'h7, 32'hFFFFFFF0, 3'b011,
                 32'hFF0, 32'h7, 1'b1};
    vecs[6]  = '{32'h10, 32'h0, 32'h4, 3'b011, 32'h10, 32'h4, 1'b0};
    vecs[7]  = '{32'h20, 32'h0, 32'h10, 3'b100, 32'h30, 32'h10, 1'b1};
    vecs[8]  = '{32'h20, 32'h0, 32'h10, 3'b110, 32'h20, 32'h10, 1'b0};
    vecs[9]  = '{32'h50, 32'h9, 32'h3, 3'b000, 32'h50, 32'h9, 1'b0};
    vecs[10] = '{32'h60, 32'h80000000, 32'h1, 3'b111,
                 32'h60, 32'h1, 1'b0};
    vecs[11] = '{32'h20, 32'h3, 32'h4, 3'b110, 32'h24, 32'h4, 1'b1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    stat_clr  = 1'b0;
    drive(32'h0, 32'h0, 32'h0, 3'b000);

    // Reset state
    step();
    step();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_npc", npc, 0);
    chk("rst_cmov", cmov_out, 0);
    chk("rst_taken", taken, 0);
    chk("rst_flush", flush, 0);
    chk("rst_br_count", br_count, 0);
    chk("rst_tk_count", tk_count, 0);
    #2 rst_n = 1'b1;
    step();
    chk("rel_in_ready", in_ready, 1);

    // BR kill window: in_ready low for exactly two cycles
    drive(32'h100, 32'h0, 32'h20, 3'b001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("br_npc", npc, 32'h120);
    chk("br_flush", flush, 1);
    chk("br_kill1", in_ready, 0);
    step();
    chk("br_flush_drop", flush, 0);
    chk("br_kill2", in_ready, 0);
    step();
    chk("br_kill_end", in_ready, 1);

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_br", br_count, 0);
    chk("clr_tk", tk_count, 0);

    // Vector table
    e_br = 0;
    e_tk = 0;
    for (int i = 0; i < 12; i++) begin
      chk($sformatf("v%0d_ready", i), in_ready, 1);
      drive(vecs[i].pc, vecs[i].av, vecs[i].bv, vecs[i].br);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk($sformatf("v%0d_valid", i), out_valid, 1);
      chk($sformatf("v%0d_npc", i), npc, vecs[i].e_npc);
      chk($sformatf("v%0d_cmov", i), cmov_out, vecs[i].e_cmov);
      chk($sformatf("v%0d_taken", i), taken, vecs[i].e_tk);
      chk($sformatf("v%0d_flush", i), flush, vecs[i].e_tk);
      chk($sformatf("v%0d_hold", i), in_ready, !vecs[i].e_tk);
      if (vecs[i].br != 3'b000 && vecs[i].br != 3'b111 && e_br < 15)
        e_br++;
      if (vecs[i].e_tk && e_tk < 15)
        e_tk++;
      step();
      step();
    end
    chk("tbl_br_count", br_count, e_br[CNT_W-1:0]);
    chk("tbl_tk_count", tk_count, e_tk[CNT_W-1:0]);

    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;

    // Backpressure on a taken result
    out_ready = 1'b0;
    drive(32'h300, 32'h0, 32'h40, 3'b001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    hold_npc = npc;
    chk("bp_npc", hold_npc, 32'h340);
    chk("bp_flush_first", flush, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("bp%0d_valid", k), out_valid, 1);
      chk($sformatf("bp%0d_npc", k), npc, 32'h340);
      chk($sformatf("bp%0d_flush", k), flush, 0);
      chk($sformatf("bp%0d_tk", k), tk_count, 0);
      chk($sformatf("bp%0d_ready", k), in_ready, 0);
    end
    out_ready = 1'b1;
    step();
    chk("bp_retire_tk", tk_count, 1);
    chk("bp_retire_valid", out_valid, 0);
    chk("bp_retire_ready", in_ready, 1);

    // Back-to-back NB throughput
    tav = '{32'hFFFFFFFD, 32'h5, 32'hFFFFFFF9, 32'h0};
    tbv = '{32'h2, 32'hFFFFFFFF, 32'hFFFFFFF7, 32'h0};
    tex = '{32'h2, 32'h5, 32'hFFFFFFF9, 32'h0};
    br0 = br_count;
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive(32'h400 + 32'(k * 4), tav[k], tbv[k], 3'b000);
      chk($sformatf("tp%0d_ready", k), in_ready, 1);
      step();
      chk($sformatf("tp%0d_valid", k), out_valid, 1);
      chk($sformatf("tp%0d_cmov", k), cmov_out, tex[k]);
      chk($sformatf("tp%0d_npc", k), npc, 32'h400 + 32'(k * 4));
    end
    in_valid = 1'b0;
    step();
    chk("tp_br_count", br_count, br0);

    // Saturation: 2^CNT_W + 3 taken retires
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    for (int k = 0; k < (1 << CNT_W) + 3; k++) begin
      drive(32'h500, 32'h0, 32'h4, 3'b001);
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
    end
    chk("sat_tk", tk_count, {CNT_W{1'b1}});
    chk("sat_br", br_count, {CNT_W{1'b1}});

    // stat_clr wins over a same-cycle retire
    drive(32'h500, 32'h0, 32'h4, 3'b001);
    out_ready = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    out_ready = 1'b1;
    stat_clr = 1'b1;
    step();
    stat_clr = 1'b0;
    chk("clr_pri_tk", tk_count, 0);
    chk("clr_pri_br", br_count, 0);
    step();
    step();

    // Reset mid-HOLD with a pending result
    out_ready = 1'b0;
    drive(32'h600, 32'h0, 32'h8, 3'b001);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mid_pending", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_npc", npc, 0);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    chk("mid_rel_ready", in_ready, 1);
    chk("mid_rel_flush", flush, 0);
    chk("mid_rel_valid", out_valid, 0);
    step();
    chk("mid_rel_flush2", flush, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
